// File: rtl/data_converter.sv
// data_converter: registered AES AddRoundKey, SubBytes and Hamming weight of one byte per clock.
// The S-box output register is the intended leakage point for power-analysis capture.
module data_converter #(
    parameter logic [7:0] KEY = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    output logic [7:0] data_out_1,
    output logic [7:0] data_out_2,
    output logic [3:0] hamming_sum
);

    // AES forward S-box (FIPS-197), index 0 first.
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Number of set bits in a byte; at most 8, so 4 bits never wrap.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    logic [7:0] x;
    logic [7:0] s;
    logic [7:0] data_out_1_d, data_out_1_q;
    logic [7:0] data_out_2_d, data_out_2_q;
    logic [3:0] hamming_sum_d, hamming_sum_q;

    // Key mixing, S-box lookup and weight, all from the same sampled byte.
    always_comb begin
        x             = data_in ^ KEY;
        s             = SBOX[x];
        data_out_1_d  = x;
        data_out_2_d  = s;
        hamming_sum_d = popcount8(s);
    end

    // Output registers; reset wins over any data on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_1_q  <= 8'h00;
            data_out_2_q  <= 8'h00;
            hamming_sum_q <= 4'h0;
        end else begin
            data_out_1_q  <= data_out_1_d;
            data_out_2_q  <= data_out_2_d;
            hamming_sum_q <= hamming_sum_d;
        end
    end

    assign data_out_1  = data_out_1_q;
    assign data_out_2  = data_out_2_q;
    assign hamming_sum = hamming_sum_q;

endmodule

// File: tb/tb_data_converter.sv
// Directed and exhaustive bench for data_converter with KEY=0 and KEY=8'h2B instances.
module tb_data_converter;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic [7:0] d1_a, d2_a, d1_k, d2_k;
    logic [3:0] hs_a, hs_k;

    int n_checks;
    int n_err;

    logic [7:0] ref_sbox [0:255];
    int         hist     [0:8];
    int         exp_hist [0:8];

    data_converter #(.KEY(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_out_1(d1_a), .data_out_2(d2_a), .hamming_sum(hs_a)
    );

    data_converter #(.KEY(8'h2B)) dut_k (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_out_1(d1_k), .data_out_2(d2_k), .hamming_sum(hs_k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) multiply with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_model(input logic [7:0] v);
        logic [7:0] inv, r1, r2, r3, r4;
        inv = 8'h00;
        if (v != 8'h00) begin
            for (int j = 1; j < 256; j++) begin
                if (gmul(v, 8'(j)) == 8'h01) inv = 8'(j);
            end
        end
        r1 = {inv[6:0], inv[7]};
        r2 = {inv[5:0], inv[7:6]};
        r3 = {inv[4:0], inv[7:5]};
        r4 = {inv[3:0], inv[7:4]};
        return inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    endfunction

    function automatic logic [7:0] weight_model(input logic [7:0] v);
        logic [7:0] n;
        n = 8'h00;
        for (int i = 0; i < 8; i++) if (v[i]) n = n + 8'h01;
        return n;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte before the edge, then settle just past the edge.
    task automatic step(input logic [7:0] din, input logic rstn);
        @(negedge clk);
        data_in = din;
        rst_n   = rstn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] held1, held2;
        logic [3:0] heldh;
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        data_in  = 8'h00;
        exp_hist = '{1, 8, 28, 56, 70, 56, 28, 8, 1};
        for (int i = 0; i < 9; i++) hist[i] = 0;
        for (int i = 0; i < 256; i++) ref_sbox[i] = sbox_model(8'(i));

        // Reset with live data on the bus.
        step(8'hA5, 1'b0);
        check("rst_d1", d1_a, 8'h00);
        check("rst_d2", d2_a, 8'h00);
        check("rst_hs", {4'h0, hs_a}, 8'h00);
        check("rst_k_d2", d2_k, 8'h00);

        // KEY=0 directed bytes; KEY=2B instance sees the same bus.
        step(8'h00, 1'b1);
        check("x00_d1", d1_a, 8'h00);
        check("x00_d2", d2_a, 8'h63);
        check("x00_hs", {4'h0, hs_a}, 8'h04);
        check("k2b_in00_d1", d1_k, 8'h2B);
        check("k2b_in00_d2", d2_k, 8'hF1);
        check("k2b_in00_hs", {4'h0, hs_k}, 8'h05);

        step(8'h01, 1'b1);
        check("x01_d1", d1_a, 8'h01);
        check("x01_d2", d2_a, 8'h7C);
        check("x01_hs", {4'h0, hs_a}, 8'h05);

        step(8'h53, 1'b1);
        check("x53_d1", d1_a, 8'h53);
        check("x53_d2", d2_a, 8'hED);
        check("x53_hs", {4'h0, hs_a}, 8'h06);

        step(8'hFF, 1'b1);
        check("xFF_d1", d1_a, 8'hFF);
        check("xFF_d2", d2_a, 8'h16);
        check("xFF_hs", {4'h0, hs_a}, 8'h03);

        step(8'h2B, 1'b1);
        check("k2b_in2b_d1", d1_k, 8'h00);
        check("k2b_in2b_d2", d2_k, 8'h63);
        check("k2b_in2b_hs", {4'h0, hs_k}, 8'h04);

        // Input change between edges must not reach the outputs.
        held1 = 8'h2B; held2 = 8'hF1; heldh = 4'h5;
        #2 data_in = 8'h5A;
        #2;
        check("hold_d1", d1_a, held1);
        check("hold_d2", d2_a, held2);
        check("hold_hs", {4'h0, hs_a}, {4'h0, heldh});

        // Exhaustive sweep against the algebraic S-box model.
        for (int i = 0; i < 256; i++) begin
            step(8'(i), 1'b1);
            check($sformatf("sw%02h_d1", i), d1_a, 8'(i));
            check($sformatf("sw%02h_d2", i), d2_a, ref_sbox[i]);
            check($sformatf("sw%02h_hs", i), {4'h0, hs_a}, weight_model(ref_sbox[i]));
            if (hs_a <= 4'd8) hist[hs_a]++;
        end
        for (int w = 0; w < 9; w++) begin
            check($sformatf("hist%0d", w), 8'(hist[w]), 8'(exp_hist[w]));
        end

        // Reset in the middle of a stream drops the byte on that edge.
        step(8'h7F, 1'b1);
        check("mid_7f_d2", d2_a, 8'hD2);
        step(8'h80, 1'b0);
        check("mid_rst_d1", d1_a, 8'h00);
        check("mid_rst_d2", d2_a, 8'h00);
        check("mid_rst_hs", {4'h0, hs_a}, 8'h00);
        step(8'h81, 1'b1);
        check("mid_81_d1", d1_a, 8'h81);
        check("mid_81_d2", d2_a, 8'h0C);
        check("mid_81_hs", {4'h0, hs_a}, 8'h02);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
